// File: rtl/alu_pair_seq.sv
// alu_pair_seq: 16-bit add/subtract/compare on register pairs, done as two
// passes through an external 8-bit alu (low byte, then high byte with the
// carry chained). While busy it owns the alu's oper/a_in_lo/b_in/flags inputs.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op             request (sampled in IDLE) and pair opcode
//                         0=addp 1=adcp 2=subp 3=sbcp 4=cmpp 5..7 illegal
//   a_hi/a_lo, b_hi/b_lo  operand pairs
//   flags_in              current processor flags
//   alu_oper_out          alu operation select
//   alu_a_lo_out          alu a_in_lo
//   alu_b_out             alu b_in
//   alu_flags_in_out      alu proc_flags_in
//   alu_out_lo            alu out_lo
//   alu_flags_out         alu proc_flags_out
//   busy, done, op_err    status (done/op_err are single-cycle pulses)
//   res_hi/res_lo         registered 16-bit result
//   flags_out             registered result flags
//
// alu_oper encoding mirrors pkg_alu: add=0, adc=1, sub=2, sbc=3.
//
// state | meaning
// IDLE  | waiting for start, alu inputs parked at add/zero
// LO    | low byte through the alu
// HI    | high byte through the alu with carry from LO
// DONE  | one-cycle done (and op_err) pulse
module alu_pair_seq #(
  parameter int INOUT_WIDTH = 8,
  parameter int FLAGS_WIDTH = 4,
  parameter int PF_SLOT_C   = 0,
  parameter int PF_SLOT_Z   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [INOUT_WIDTH-1:0] a_hi,
  input  logic [INOUT_WIDTH-1:0] a_lo,
  input  logic [INOUT_WIDTH-1:0] b_hi,
  input  logic [INOUT_WIDTH-1:0] b_lo,
  input  logic [FLAGS_WIDTH-1:0] flags_in,
  output logic [3:0]             alu_oper_out,
  output logic [INOUT_WIDTH-1:0] alu_a_lo_out,
  output logic [INOUT_WIDTH-1:0] alu_b_out,
  output logic [FLAGS_WIDTH-1:0] alu_flags_in_out,
  input  logic [INOUT_WIDTH-1:0] alu_out_lo,
  input  logic [FLAGS_WIDTH-1:0] alu_flags_out,
  output logic                   busy,
  output logic                   done,
  output logic                   op_err,
  output logic [INOUT_WIDTH-1:0] res_hi,
  output logic [INOUT_WIDTH-1:0] res_lo,
  output logic [FLAGS_WIDTH-1:0] flags_out
);

  localparam logic [3:0] alu_op_add = 4'd0;
  localparam logic [3:0] alu_op_adc = 4'd1;
  localparam logic [3:0] alu_op_sub = 4'd2;
  localparam logic [3:0] alu_op_sbc = 4'd3;

  localparam logic [2:0] op_addp = 3'd0;
  localparam logic [2:0] op_adcp = 3'd1;
  localparam logic [2:0] op_subp = 3'd2;
  localparam logic [2:0] op_sbcp = 3'd3;
  localparam logic [2:0] op_cmpp = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             op_q;
  logic [INOUT_WIDTH-1:0] a_hi_q, a_lo_q, b_hi_q, b_lo_q;
  logic [FLAGS_WIDTH-1:0] flags_q;
  logic                   err_q;
  logic [INOUT_WIDTH-1:0] lo_byte;
  logic                   lo_c, lo_z;
  logic [FLAGS_WIDTH-1:0] hi_flags_in;
  logic [FLAGS_WIDTH-1:0] res_flags;
  logic                   op_legal;
  logic                   hi_zero;
  logic                   unused_alu_flags;

  assign op_legal = (op <= op_cmpp);
  assign hi_zero  = (alu_out_lo == '0);
  // Only the carry comes back from the alu; its other flag outputs are ignored.
  assign unused_alu_flags = ^alu_flags_out;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = op_legal ? S_LO : S_DONE;
      S_LO:   state_d = S_HI;
      S_HI:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_flags_in            = flags_q;
    hi_flags_in[PF_SLOT_C] = lo_c;
    res_flags              = flags_q;
    res_flags[PF_SLOT_C]   = alu_flags_out[PF_SLOT_C];
    res_flags[PF_SLOT_Z]   = lo_z & hi_zero;
  end

  always_comb begin
    alu_oper_out     = alu_op_add;
    alu_a_lo_out     = '0;
    alu_b_out        = '0;
    alu_flags_in_out = '0;
    busy             = 1'b0;
    done             = 1'b0;
    op_err           = 1'b0;
    case (state_q)
      S_LO: begin
        busy             = 1'b1;
        alu_a_lo_out     = a_lo_q;
        alu_b_out        = b_lo_q;
        alu_flags_in_out = flags_q;
        case (op_q)
          op_adcp: alu_oper_out = alu_op_adc;
          op_subp: alu_oper_out = alu_op_sub;
          op_sbcp: alu_oper_out = alu_op_sbc;
          op_cmpp: alu_oper_out = alu_op_sub;
          default: alu_oper_out = alu_op_add;
        endcase
      end
      S_HI: begin
        busy             = 1'b1;
        alu_a_lo_out     = a_hi_q;
        alu_b_out        = b_hi_q;
        alu_flags_in_out = hi_flags_in;
        alu_oper_out     = (op_q == op_addp || op_q == op_adcp) ? alu_op_adc : alu_op_sbc;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        op_err = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_hi_q    <= '0;
      a_lo_q    <= '0;
      b_hi_q    <= '0;
      b_lo_q    <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      lo_byte   <= '0;
      lo_c      <= 1'b0;
      lo_z      <= 1'b0;
      res_hi    <= '0;
      res_lo    <= '0;
      flags_out <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_hi_q  <= a_hi;
            a_lo_q  <= a_lo;
            b_hi_q  <= b_hi;
            b_lo_q  <= b_lo;
            flags_q <= flags_in;
            err_q   <= !op_legal;
            // Illegal ops skip the alu entirely; flags are reported unchanged.
            if (!op_legal) flags_out <= flags_in;
          end
        end
        S_LO: begin
          lo_byte <= alu_out_lo;
          lo_c    <= alu_flags_out[PF_SLOT_C];
          lo_z    <= hi_zero;
        end
        S_HI: begin
          if (op_q != op_cmpp) begin
            res_hi <= alu_out_lo;
            res_lo <= lo_byte;
          end
          flags_out <= res_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pair_seq.sv
module tb_alu_pair_seq;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] op;
  logic [7:0] a_hi, a_lo, b_hi, b_lo;
  logic [3:0] flags_in;
  logic [3:0] alu_oper_out;
  logic [7:0] alu_a_lo_out, alu_b_out, alu_out_lo;
  logic [3:0] alu_flags_in_out, alu_flags_out;
  logic       busy, done, op_err;
  logic [7:0] res_hi, res_lo;
  logic [3:0] flags_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_res;
  bit          res_known;

  always #5 clk = ~clk;

  alu_pair_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_hi(a_hi), .a_lo(a_lo), .b_hi(b_hi), .b_lo(b_lo), .flags_in(flags_in),
    .alu_oper_out(alu_oper_out), .alu_a_lo_out(alu_a_lo_out), .alu_b_out(alu_b_out),
    .alu_flags_in_out(alu_flags_in_out), .alu_out_lo(alu_out_lo),
    .alu_flags_out(alu_flags_out), .busy(busy), .done(done), .op_err(op_err),
    .res_hi(res_hi), .res_lo(res_lo), .flags_out(flags_out)
  );

  // 8-bit alu stand-in: add=0, adc=1, sub=2, sbc=3; C=1 means no borrow.
  logic [8:0] alu_r;
  always_comb begin
    case (alu_oper_out)
      4'd0: alu_r = {1'b0, alu_a_lo_out} + {1'b0, alu_b_out};
      4'd1: alu_r = {1'b0, alu_a_lo_out} + {1'b0, alu_b_out} + {8'd0, alu_flags_in_out[0]};
      4'd2: alu_r = {1'b0, alu_a_lo_out} + {1'b0, ~alu_b_out} + 9'd1;
      4'd3: alu_r = {1'b0, alu_a_lo_out} + {1'b0, ~alu_b_out} + {8'd0, alu_flags_in_out[0]};
      default: alu_r = '0;
    endcase
    alu_out_lo       = alu_r[7:0];
    alu_flags_out    = alu_flags_in_out;
    alu_flags_out[0] = alu_r[8];
    alu_flags_out[1] = (alu_r[7:0] == 8'd0);
  end

  // Whole-word reference: returns {flags, result16}.
  function automatic logic [19:0] ref_op(input logic [2:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [3:0]  nf;
    case (o)
      3'd0:       s = {1'b0, a} + {1'b0, b};
      3'd1:       s = {1'b0, a} + {1'b0, b} + {16'd0, f[0]};
      3'd2, 3'd4: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd3:       s = {1'b0, a} + {1'b0, ~b} + {16'd0, f[0]};
      default:    s = '0;
    endcase
    nf = f;
    if (o <= 3'd4) begin
      nf[0] = s[16];
      nf[1] = (s[15:0] == 16'd0);
    end
    return {nf, s[15:0]};
  endfunction

  // Drives one request, scrambles the operand inputs while busy, and
  // reports latency (edges from the sampling edge to done, -1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output int lat, output logic err,
                        output logic [15:0] res, output logic [3:0] fl, output logic done_next);
    @(negedge clk);
    op = o; {a_hi, a_lo} = a; {b_hi, b_lo} = b; flags_in = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a_hi = 8'($urandom); a_lo = 8'($urandom);
    b_hi = 8'($urandom); b_lo = 8'($urandom); flags_in = 4'($urandom);
    lat = -1; err = 1'b0; res = '0; fl = '0; done_next = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (done === 1'b1) begin
        lat = i; err = op_err; res = {res_hi, res_lo}; fl = flags_out;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      done_next = done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a_hi = '0; a_lo = '0; b_hi = '0; b_lo = '0; flags_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done, op_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, op_err}); end
    checks++; if ({res_hi, res_lo} !== 16'h0000) begin errors++; $display("FAIL reset_res: got %h want 0000", {res_hi, res_lo}); end
    checks++; if (flags_out !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", flags_out); end
    checks++; if ({alu_oper_out, alu_a_lo_out, alu_b_out, alu_flags_in_out} !== 24'h0) begin
      errors++; $display("FAIL reset_alu_drive: got %h want 000000", {alu_oper_out, alu_a_lo_out, alu_b_out, alu_flags_in_out}); end
    @(negedge clk); reset = 1'b0;
    model_res = 16'h0; res_known = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    run_op(3'd0, 16'h12FF, 16'h0001, 4'h0, lat, err, r, fl, dn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL addp_latency: got %0d want 3", lat); end
    checks++; if (r !== 16'h1300) begin errors++; $display("FAIL addp_res: got %h want 1300", r); end
    checks++; if (fl !== 4'h0) begin errors++; $display("FAIL addp_flags: got %h want 0", fl); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL addp_done_width: got %b want 0", dn); end
    run_op(3'd0, 16'hFFFF, 16'h0001, 4'hC, lat, err, r, fl, dn);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL addp_wrap_res: got %h want 0000", r); end
    checks++; if (fl !== 4'hF) begin errors++; $display("FAIL addp_wrap_flags: got %h want f", fl); end
    model_res = 16'h0000;
  endtask

  task automatic test_adc_sub();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    run_op(3'd1, 16'h00FF, 16'h0000, 4'h1, lat, err, r, fl, dn);
    checks++; if (r !== 16'h0100) begin errors++; $display("FAIL adcp_res: got %h want 0100", r); end
    checks++; if (fl !== 4'h0) begin errors++; $display("FAIL adcp_flags: got %h want 0", fl); end
    run_op(3'd2, 16'h1000, 16'h0001, 4'h0, lat, err, r, fl, dn);
    checks++; if (r !== 16'h0FFF) begin errors++; $display("FAIL subp_res: got %h want 0fff", r); end
    checks++; if (fl !== 4'h1) begin errors++; $display("FAIL subp_flags: got %h want 1", fl); end
    model_res = 16'h0FFF;
  endtask

  task automatic test_cmpp();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    run_op(3'd0, 16'hABCD, 16'h0000, 4'h0, lat, err, r, fl, dn);
    checks++; if (r !== 16'hABCD) begin errors++; $display("FAIL cmpp_setup_res: got %h want abcd", r); end
    run_op(3'd4, 16'h1234, 16'h1234, 4'h0, lat, err, r, fl, dn);
    checks++; if (r !== 16'hABCD) begin errors++; $display("FAIL cmpp_eq_res_held: got %h want abcd", r); end
    checks++; if (fl !== 4'h3) begin errors++; $display("FAIL cmpp_eq_flags: got %h want 3", fl); end
    run_op(3'd4, 16'h0001, 16'h0002, 4'h0, lat, err, r, fl, dn);
    checks++; if (fl !== 4'h0) begin errors++; $display("FAIL cmpp_lt_flags: got %h want 0", fl); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL cmpp_latency: got %0d want 3", lat); end
    model_res = 16'hABCD;
  endtask

  task automatic test_illegal();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    run_op(3'd6, 16'h5555, 16'h2222, 4'hA, lat, err, r, fl, dn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_op_err: got %b want 1", err); end
    checks++; if (fl !== 4'hA) begin errors++; $display("FAIL illegal_flags: got %h want a", fl); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL illegal_done_width: got %b want 0", dn); end
    res_known = 1'b0;
    run_op(3'd0, 16'h0001, 16'h0001, 4'h0, lat, err, r, fl, dn);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL legal_after_illegal_err: got %b want 0", err); end
    model_res = 16'h0002; res_known = 1'b1;
  endtask

  task automatic test_busy_start();
    int n_done = 0;
    logic [15:0] r = '0;
    @(negedge clk);
    op = 3'd0; {a_hi, a_lo} = 16'h0102; {b_hi, b_lo} = 16'h0304; flags_in = 4'h0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin n_done++; r = {res_hi, res_lo}; end
      start = (i < 2);
      op = 3'd2; a_hi = 8'($urandom); a_lo = 8'($urandom); b_hi = 8'($urandom); b_lo = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", n_done); end
    checks++; if (r !== 16'h0406) begin errors++; $display("FAIL busy_start_res: got %h want 0406", r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b want 0", busy); end
    model_res = 16'h0406;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    int n_done = 0;
    @(negedge clk);
    op = 3'd0; {a_hi, a_lo} = 16'h4321; {b_hi, b_lo} = 16'h1111; flags_in = 4'h4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mid_reset_status: got %b want 00", {busy, done}); end
    checks++; if ({res_hi, res_lo, flags_out} !== 20'h0) begin errors++; $display("FAIL mid_reset_regs: got %h want 00000", {res_hi, res_lo, flags_out}); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d want 0", n_done); end
    run_op(3'd0, 16'h4321, 16'h1111, 4'h4, lat, err, r, fl, dn);
    checks++; if (r !== 16'h5432 || lat !== 3) begin errors++; $display("FAIL mid_reset_recover: got res %h lat %0d want 5432 lat 3", r, lat); end
    model_res = 16'h5432; res_known = 1'b1;
  endtask

  task automatic test_random();
    int lat; logic err, dn; logic [15:0] r; logic [3:0] fl;
    logic [2:0] o; logic [15:0] a, b; logic [3:0] f; logic [19:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
      if (i % 8 == 0) b = a;
      exp_v = ref_op(o, a, b, f);
      run_op(o, a, b, f, lat, err, r, fl, dn);
      checks++; if (fl !== exp_v[19:16]) begin errors++; $display("FAIL rand_flags[%0d] op%0d: got %h want %h", i, o, fl, exp_v[19:16]); end
      checks++; if (lat !== ((o <= 3'd4) ? 3 : 1) || err !== (o > 3'd4)) begin
        errors++; $display("FAIL rand_timing[%0d] op%0d: got lat %0d err %b", i, o, lat, err); end
      if (o > 3'd4) res_known = 1'b0;
      else begin
        if (o != 3'd4) begin model_res = exp_v[15:0]; res_known = 1'b1; end
        if (res_known) begin
          checks++; if (r !== model_res) begin errors++; $display("FAIL rand_res[%0d] op%0d: got %h want %h", i, o, r, model_res); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc_sub();
    test_cmpp();
    test_illegal();
    test_busy_start();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
